// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch unit's instruction-memory, decode and redirect signals.
//   imem_req/imem_addr/imem_ack/imem_rdata : request/ack handshake to instruction memory
//   instr_valid/instr/instr_pc/instr_ready  : instruction stream to decode (valid/ready)
//   PCSrc/PCTarget                          : redirect from controller/datapath
//   fetch_misaligned                        : misaligned-redirect halt flag, only present
//                                             when FETCH_MISALIGN_CHECK_EN is defined
// Modports: master = fetch unit side, slave = memory/decode/controller side.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] PCTarget;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
        output fetch_misaligned,
`endif
        input  imem_ack, imem_rdata, instr_ready, PCSrc, PCTarget
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
        input  fetch_misaligned,
`endif
        output imem_ack, imem_rdata, instr_ready, PCSrc, PCTarget
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Owns the fetch PC, issues word fetches over a req/ack handshake, buffers returned words with
// their PCs in a FIFO_DEPTH-entry FIFO and presents the head to decode under valid/ready.
// A redirect (PCSrc) flushes the FIFO; if a request is already outstanding it is completed at
// its old address and its word dropped (DROP state) before fetching resumes at the target.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : fetch_unit_if.master (imem handshake, decode stream, redirect inputs)
// Optional macro FETCH_MISALIGN_CHECK_EN: a redirect that loads a non word-aligned target
// enters HALT (no requests, no valid output, fetch_misaligned=1) until reset. Without it the
// low two target bits are forced to zero.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {RUN, DROP, HALT} state_t;
`else
    typedef enum logic [1:0] {RUN, DROP} state_t;
`endif

    state_t      state;
    logic [31:0] fpc;
    logic [31:0] pend_pc;
    logic [31:0] fifo_instr [FIFO_DEPTH];
    logic [31:0] fifo_pc    [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic        req;
    logic        xfer;
    logic        push;
    logic        pop;
    logic        valid;
    logic [31:0] target;
    logic        load_en;
    logic [31:0] load_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;
    assign target = bus.PCTarget;
    assign bus.fetch_misaligned = misaligned;
`else
    assign target = {bus.PCTarget[31:2], 2'b00};
`endif

    // In DROP the outstanding request must complete even when the FIFO is full.
    always_comb begin
        req = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN:     req = (count != FULL_COUNT);
                DROP:    req = 1'b1;
                default: req = 1'b0;
            endcase
        end
    end

    assign xfer  = req && bus.imem_ack;
    assign valid = !reset && (count != '0) && (state == RUN || state == DROP);
    assign push  = (state == RUN) && xfer && !bus.PCSrc;
    assign pop   = valid && bus.instr_ready;

    // fpc loads: immediate redirect in RUN, or completion of the dropped request in DROP.
    always_comb begin
        load_en = 1'b0;
        load_pc = target;
        unique case (state)
            RUN: load_en = bus.PCSrc && (xfer || !req);
            DROP: begin
                load_en = xfer;
                load_pc = bus.PCSrc ? target : pend_pc;
            end
            default: load_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            fpc     <= RESET_PC;
            pend_pc <= RESET_PC;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned <= 1'b0;
`endif
        end else begin
            // FIFO bookkeeping; a redirect flush overrides any pop in the same cycle.
            if (bus.PCSrc) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            if (load_en) begin
                fpc   <= load_pc;
                state <= RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
                if (load_pc[1:0] != 2'b00) begin
                    state      <= HALT;
                    misaligned <= 1'b1;
                end
`endif
            end else begin
                unique case (state)
                    RUN: begin
                        if (bus.PCSrc) begin
                            pend_pc <= target;
                            state   <= DROP;
                        end else if (xfer) begin
                            fpc <= fpc + 32'd4;
                        end
                    end
                    DROP: begin
                        if (bus.PCSrc) pend_pc <= target;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only observed when count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]    <= fpc;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fpc;
    assign bus.instr_valid = valid;
    assign bus.instr       = fifo_instr[rd_ptr];
    assign bus.instr_pc    = fifo_pc[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (default build, RESET_PC=0, FIFO_DEPTH=2).
// A queue-based reference model tracks fetch PC, pending redirect and buffered {instr, pc}
// entries; every cycle the DUT's request, address and decode outputs are compared against it.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [31:0] m_fpc;
    logic [31:0] m_pend;
    bit          m_drop;
    logic [63:0] m_q[$];   // {instr, pc}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic cyc(input bit rst, input bit ack, input bit rdy, input bit src,
                       input logic [31:0] tgt);
        bit          e_req;
        bit          xfer;
        logic [31:0] t;
        logic [63:0] head;
        @(negedge clk);
        reset           = rst;
        bus.imem_ack    = ack;
        bus.instr_ready = rdy;
        bus.PCSrc       = src;
        bus.PCTarget    = tgt;
        bus.imem_rdata  = $urandom;
        #1;
        e_req = !rst && (m_drop || m_q.size() < DEPTH);
        check("req", {31'd0, bus.imem_req}, {31'd0, e_req});
        check("valid", {31'd0, bus.instr_valid}, {31'd0, !rst && m_q.size() != 0});
        if (!rst) begin
            check("addr", bus.imem_addr, m_fpc);
            if (m_q.size() != 0) begin
                head = m_q[0];
                check("instr", bus.instr, head[63:32]);
                check("pc", bus.instr_pc, head[31:0]);
            end
        end

        if (rst) begin
            m_fpc  = RST_PC;
            m_pend = RST_PC;
            m_drop = 0;
            m_q.delete();
        end else begin
            xfer = e_req && ack;
            t    = {tgt[31:2], 2'b00};
            if (src) begin
                m_q.delete();
                if (m_drop) begin
                    if (xfer) begin m_fpc = t; m_drop = 0; end
                    else m_pend = t;
                end else if (xfer || !e_req) begin
                    m_fpc = t;
                end else begin
                    m_pend = t;
                    m_drop = 1;
                end
            end else begin
                if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
                if (m_drop) begin
                    if (xfer) begin m_fpc = m_pend; m_drop = 0; end
                end else if (xfer) begin
                    m_q.push_back({bus.imem_rdata, m_fpc});
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
    endtask

    logic [31:0] tgts [6];

    initial begin
        tgts[0] = 32'h0000_0100;
        tgts[1] = 32'h0000_0200;
        tgts[2] = 32'h0000_0040;
        tgts[3] = 32'hFFFF_FFF8;   // exercises fpc wrap
        tgts[4] = 32'h0000_0102;   // misaligned, low bits dropped
        tgts[5] = 32'h0000_1233;
        m_fpc = RST_PC; m_pend = RST_PC; m_drop = 0;
        reset = 1'b1;
        bus.imem_ack = 0; bus.instr_ready = 0; bus.PCSrc = 0; bus.PCTarget = '0;
        bus.imem_rdata = '0;

        repeat (2) cyc(1, 0, 0, 0, 0);
        // Streaming at full rate.
        repeat (6) cyc(0, 1, 1, 0, 0);
        // Back-pressure: fill, stall, drain.
        cyc(1, 0, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0, 0);
        repeat (4) cyc(0, 1, 1, 0, 0);
        // Redirect with full FIFO and no outstanding request.
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h100);
        repeat (3) cyc(0, 1, 1, 0, 0);
        // Delayed ack with redirect in the first wait cycle (DROP path).
        cyc(0, 0, 1, 1, 32'h200);
        repeat (2) cyc(0, 0, 1, 0, 0);
        repeat (3) cyc(0, 1, 1, 0, 0);
        // Redirect coinciding with a transfer.
        cyc(0, 1, 1, 1, 32'h40);
        repeat (2) cyc(0, 1, 1, 0, 0);
        // Reset asserted while in DROP.
        cyc(0, 0, 1, 1, 32'h300);
        cyc(1, 0, 1, 0, 0);
        repeat (2) cyc(0, 1, 1, 0, 0);
        // Misaligned target gets word-aligned.
        cyc(0, 0, 0, 1, 32'h102);
        repeat (3) cyc(0, 1, 1, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 9) < 6,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 99) < 8,
                ($urandom_range(0, 3) == 0) ? $urandom : tgts[$urandom_range(0, 5)]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end for the RISC-V core. Owns the fetch PC and issues requests to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents them to decode under valid/ready.
- Consumes the redirect produced by the controller and datapath: PCSrc, the branch/jump decision, and PCTarget, the resolved target. Flushes wrong-path instructions on redirect.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, word aligned
imem_ack  input  1  request accepted, imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
instr_valid  output  1  FIFO head valid
instr  output  32  FIFO head instruction
instr_pc  output  32  PC of FIFO head
instr_ready  input  1  decode accepts head
PCSrc  input  1  redirect request (branch taken / jump)
PCTarget  input  32  redirect target

Behaviour:
- Registers:
  - fpc: fetch PC.
  - pend_pc: pending target.
  - FIFO of {instr, pc}, with count.
  - state in {RUN, DROP}.
- Reset (synchronous, wins over everything):
  - fpc=RESET_PC, count=0, state=RUN.
  - imem_req=0 and instr_valid=0 while reset is high.
  - instr and instr_pc are don't-care when invalid.
- imem_addr = fpc in all states; imem_req = (state==DROP) | (count<FIFO_DEPTH).
- A transfer occurs on imem_req & imem_ack. imem_addr stays stable from req assertion until the transfer.
- Zero-wait memory: ack may be high in the same cycle as req.
- RUN, transfer, no redirect: push {imem_rdata, fpc}; fpc+=4.
- RUN, no transfer:
  - PCSrc=1 with imem_req=1: pend_pc=PCTarget; go to DROP.
  - PCSrc=1 with imem_req=0: fpc=PCTarget; stay in RUN.
- RUN, transfer and PCSrc=1 in the same cycle: discard the returned word; fpc=PCTarget; stay in RUN.
- DROP:
  - imem_req=1 at the old fpc; no pushes.
  - On transfer: discard the word; fpc=pend_pc (or PCTarget if PCSrc=1 that cycle); go to RUN.
  - PCSrc=1 without transfer: pend_pc=PCTarget (last redirect wins).
- Any PCSrc=1: FIFO flushed (count=0) at that clock edge. instr_valid=0 the next cycle. A simultaneous pop is ignored.
- Pop on instr_valid & instr_ready; push and pop may occur in the same cycle.
- instr_valid = count!=0. Head fields stay stable while instr_valid & !instr_ready.
- Full (count==FIFO_DEPTH): no request. Empty: instr_valid=0. No overflow is possible because requests are gated by count.
- fpc wraps modulo 2^32: 0xFFFF_FFFC+4 = 0x0.
- Latency: word acked in cycle N appears at instr in N+1.
- Throughput: 1 instr/cycle with zero-wait ack and instr_ready=1.
- PCTarget[1:0] handling: see Optional Feature.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - Adds state HALT, entered when a redirect is taken with PCTarget[1:0]!=2'b00 (FIFO flushed). This applies to both immediate and DROP-path redirects.
  - In HALT: imem_req=0, instr_valid=0, fetch_misaligned=1 until reset.
- Undefined: PCTarget[1:0] forced to 2'b00 on load; no extra port.

Test Plan:
- Reset with RESET_PC=0, ack every cycle, instr_ready=1 -> imem_addr 0,4,8,... one per cycle; instr_valid from the 2nd cycle; instr_pc 0,4,8 in order.
- instr_ready=0 from start -> two pushes, then imem_req=0 with head pc=0 stable. Raise ready -> pops pc 0,4; requests resume at 0x8.
- PCSrc=1, PCTarget=0x100 with FIFO holding 2 entries and no outstanding req -> instr_valid=0 next cycle; next imem_addr=0x100; first delivered instr_pc=0x100.
- Ack delayed 3 cycles on addr 0x8; PCSrc=1, PCTarget=0x200 in the 1st wait cycle -> imem_addr holds 0x8 until ack; that word is never delivered; next request at 0x200.
- PCSrc=1, PCTarget=0x40 in the same cycle as an ack for 0xC -> 0xC word discarded; next imem_addr=0x40. Also assert reset during DROP -> next addr=RESET_PC, count=0.
- With FETCH_MISALIGN_CHECK_EN: PCSrc=1, PCTarget=0x102 -> fetch_misaligned=1, imem_req=0 until reset. Without the macro -> next imem_addr=0x100.
